// File: rtl/fdcp_ff_pkg.sv
// Shared helpers for the fdcp_ff storage primitive: decode of the async controls
// into the clear and set levels that drive each cell.
package fdcp_ff_pkg;

  localparam int unsigned DefaultWidth = 1;

  function automatic logic force_clear(logic rst, logic clr);
    return !rst || clr;
  endfunction

  // Preset only wins when neither reset nor clear is active.
  function automatic logic force_set(logic rst, logic clr, logic pre);
    return rst && !clr && pre;
  endfunction

endpackage

// File: rtl/fdcp_ff_if.sv
// Data/control bundle for a bank of fdcp cells; clock and reset stay plain ports.
interface fdcp_ff_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] pre;
  logic [WIDTH-1:0] q;

  modport master (
    output d,
    output clr,
    output pre,
    input  q
  );

  modport slave (
    input  d,
    input  clr,
    input  pre,
    output q
  );
endinterface

// File: rtl/fdcp_bit.sv
// One D flip-flop cell with asynchronous clear and preset under a global active-low reset.
module fdcp_bit
  import fdcp_ff_pkg::*;
#(
  parameter logic INIT = 1'b0
) (
  input  logic c,
  input  logic rst,
  input  logic d,
  input  logic clr,
  input  logic pre,
  output logic q
);

  logic force_clr;
  logic force_pre;
  logic q_r = INIT;

  // Controls are folded into two level signals so that releasing a stronger control
  // while a weaker one is still held (e.g. RST rising with PRE high) retakes effect.
  always_comb begin
    force_clr = force_clear(rst, clr);
    force_pre = force_set(rst, clr, pre);
  end

  always_ff @(posedge c or posedge force_clr or posedge force_pre) begin
    if (force_clr) begin
      q_r <= 1'b0;
    end else if (force_pre) begin
      q_r <= 1'b1;
    end else begin
      q_r <= d;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/fdcp_ff.sv
// Bank of WIDTH independent fdcp cells sharing one clock and one reset.
module fdcp_ff
  import fdcp_ff_pkg::*;
#(
  parameter int unsigned      WIDTH = DefaultWidth,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic        c,
  input  logic        rst,
  fdcp_ff_if.slave    bus
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fdcp_bit #(
      .INIT(INIT[i])
    ) u_bit (
      .c  (c),
      .rst(rst),
      .d  (bus.d[i]),
      .clr(bus.clr[i]),
      .pre(bus.pre[i]),
      .q  (bus.q[i])
    );
  end

endmodule

// File: tb/tb_fdcp_ff.sv
// Directed bench for a 4-bit fdcp_ff bank with an expected-value scoreboard.
module tb_fdcp_ff;

  localparam int unsigned W = 4;

  logic c;
  logic rst;
  int   tests;
  int   failed;
  logic [W-1:0] exp_q[$];

  fdcp_ff_if #(.WIDTH(W)) bus ();

  fdcp_ff #(
    .WIDTH(W),
    .INIT ('0)
  ) dut (
    .c  (c),
    .rst(rst),
    .bus(bus)
  );

  task automatic expect_q(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  // Sample 1 time unit after the last stimulus change, away from any clock edge.
  task automatic check(input string tag);
    logic [W-1:0] e;
    #1;
    tests++;
    if (exp_q.size() == 0) begin
      failed++;
      $error("FAIL %s: scoreboard empty, q=%b", tag, bus.q);
    end else begin
      e = exp_q.pop_front();
      assert (bus.q === e) else begin
        failed++;
        $error("FAIL %s: q=%b expected=%b", tag, bus.q, e);
      end
    end
  endtask

  task automatic pulse_c();
    #4;
    c = 1'b1;
    #5;
    c = 1'b0;
    #1;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    c      = 1'b0;
    rst    = 1'b0;
    bus.d   = '0;
    bus.clr = '0;
    bus.pre = 4'b0001;

    // Reset dominates preset, then preset takes over on release with no clock.
    expect_q(4'b0000); check("reset_hold_pre");
    rst = 1'b1;
    expect_q(4'b0001); check("rst_release_pre");
    bus.pre = '0;
    expect_q(4'b0001); check("pre_release_hold");
    pulse_c();
    expect_q(4'b0000); check("clk_load_0");

    // Clocked load, one edge of latency.
    bus.d = 4'b0001;
    expect_q(4'b0000); check("d_no_edge");
    pulse_c();
    expect_q(4'b0001); check("clk_load_1");
    bus.d = 4'b0000;
    pulse_c();
    expect_q(4'b0000); check("clk_load_0b");

    // Async preset then clocked clear.
    bus.pre = 4'b0001;
    expect_q(4'b0001); check("pre_immediate");
    bus.pre = '0;
    expect_q(4'b0001); check("pre_held");
    pulse_c();
    expect_q(4'b0000); check("clk_after_pre");

    // Latch mode, C held low.
    bus.pre = 4'b0001; #2; bus.pre = '0;
    expect_q(4'b0001); check("latch_set");
    bus.clr = 4'b0001; #2; bus.clr = '0;
    expect_q(4'b0000); check("latch_clr");
    bus.pre = 4'b0001; bus.clr = 4'b0001;
    expect_q(4'b0000); check("latch_both");
    bus.clr = '0;
    expect_q(4'b0001); check("latch_clr_rel_pre_held");
    bus.pre = '0;
    expect_q(4'b0001); check("latch_hold");
    bus.clr = 4'b0001; #2; bus.clr = '0;
    expect_q(4'b0000); check("latch_clr2");

    // Preset dominates the clock.
    bus.d   = '0;
    bus.pre = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      pulse_c();
      expect_q(4'b0001); check("pre_over_clk");
    end
    bus.pre = '0;
    pulse_c();
    expect_q(4'b0000); check("pre_rel_clk");

    // Reset in the middle of operation.
    bus.d = 4'b1111;
    pulse_c();
    expect_q(4'b1111); check("load_all");
    rst = 1'b0;
    expect_q(4'b0000); check("rst_mid");
    pulse_c();
    expect_q(4'b0000); check("clk_in_rst");
    rst = 1'b1;
    expect_q(4'b0000); check("rst_rel_hold");
    pulse_c();
    expect_q(4'b1111); check("first_clk_after_rst");

    // Per-bit independence.
    bus.d = '0;
    pulse_c();
    expect_q(4'b0000); check("w_clear");
    bus.pre = 4'b0101;
    expect_q(4'b0101); check("w_pre");
    bus.clr = 4'b0001;
    expect_q(4'b0100); check("w_clr");
    bus.pre = '0; bus.clr = '0;
    expect_q(4'b0100); check("w_release");
    bus.d = 4'b1010;
    pulse_c();
    expect_q(4'b1010); check("w_load");
    bus.clr = 4'b0010;
    expect_q(4'b1000); check("w_clr_bit1");
    bus.d = 4'b1111;
    pulse_c();
    expect_q(4'b1101); check("w_clr_over_clk");
    bus.clr = '0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
